// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a starved fetch takes the port at STARVE_LIMIT.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ifReq,
    input  logic [31:0]       i_ifAddr,
    output logic              o_ifGnt,
    output logic              o_ifRvalid,
    output logic [31:0]       o_ifRdata,
    input  logic              i_dReq,
    input  logic [31:0]       i_dAddr,
    input  logic              i_dWe,
    input  logic [1:0]        i_dSize,
    input  logic              i_dSign,
    input  logic [31:0]       i_dWdata,
    output logic              o_dGnt,
    output logic              o_dRvalid,
    output logic [31:0]       o_dRdata,
    output logic              o_dErr,
    output logic              o_memEn,
    output logic              o_memWe,
    output logic [3:0]        o_memBe,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memWdata,
    input  logic [31:0]       i_memRdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DLOAD,
        OWN_DERR
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_q, starve_d;
    owner_e      owner_q, owner_d;
    logic [1:0]  offset_q, offset_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        if_win, d_win, d_err;
    logic [31:0] ld_shift, ld_data;
    logic        unused_addr;

    assign unused_addr = ^{i_ifAddr[31:ADDR_W], i_dAddr[31:ADDR_W]};

    always_comb begin
        unique case (i_dSize)
            2'b00:   d_err = 1'b0;
            2'b01:   d_err = i_dAddr[0];
            2'b10:   d_err = |i_dAddr[1:0];
            default: d_err = 1'b1;
        endcase
    end

    // Reset masks the grants so no memory traffic leaks while it is held.
    assign if_win = !i_reset && i_ifReq && (!i_dReq || starve_q == LIMIT);
    assign d_win  = !i_reset && i_dReq && !if_win;

    always_comb begin
        o_ifGnt    = if_win;
        o_dGnt     = d_win;
        o_memEn    = 1'b0;
        o_memWe    = 1'b0;
        o_memBe    = 4'b0000;
        o_memAddr  = '0;
        o_memWdata = 32'h0;
        owner_d    = OWN_NONE;
        offset_d   = offset_q;
        size_d     = size_q;
        sign_d     = sign_q;
        starve_d   = starve_q;

        if (!i_ifReq || if_win) begin
            starve_d = 4'd0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end

        if (if_win) begin
            o_memEn   = 1'b1;
            o_memBe   = 4'hF;
            o_memAddr = i_ifAddr[ADDR_W-1:0];
            owner_d   = OWN_IF;
        end else if (d_win) begin
            if (d_err) begin
                owner_d = OWN_DERR;
            end else begin
                o_memEn    = 1'b1;
                o_memWe    = i_dWe;
                o_memAddr  = i_dAddr[ADDR_W-1:0];
                o_memWdata = i_dWdata << {i_dAddr[1:0], 3'b000};
                unique case (i_dSize)
                    2'b00:   o_memBe = 4'b0001 << i_dAddr[1:0];
                    2'b01:   o_memBe = 4'b0011 << i_dAddr[1:0];
                    default: o_memBe = 4'hF;
                endcase
                if (!i_dWe) begin
                    owner_d  = OWN_DLOAD;
                    offset_d = i_dAddr[1:0];
                    size_d   = i_dSize;
                    sign_d   = i_dSign;
                end
            end
        end
    end

    // sign_q set means zero-extend (LBU/LHU).
    always_comb begin
        ld_shift = i_memRdata >> {offset_q, 3'b000};
        unique case (size_q)
            2'b00: ld_data = sign_q ? {24'h0, ld_shift[7:0]}
                                    : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01: ld_data = sign_q ? {16'h0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    assign o_ifRvalid = (owner_q == OWN_IF);
    assign o_ifRdata  = o_ifRvalid ? i_memRdata : 32'h0;
    assign o_dRvalid  = (owner_q == OWN_DLOAD) || (owner_q == OWN_DERR);
    assign o_dErr     = (owner_q == OWN_DERR);
    assign o_dRdata   = (owner_q == OWN_DLOAD) ? ld_data : 32'h0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_q <= 4'd0;
            owner_q  <= OWN_NONE;
            offset_q <= 2'b00;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            offset_q <= offset_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a clocked memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_ifReq;
    logic [31:0] i_ifAddr;
    logic        o_ifGnt, o_ifRvalid;
    logic [31:0] o_ifRdata;
    logic        i_dReq;
    logic [31:0] i_dAddr;
    logic        i_dWe;
    logic [1:0]  i_dSize;
    logic        i_dSign;
    logic [31:0] i_dWdata;
    logic        o_dGnt, o_dRvalid, o_dErr;
    logic [31:0] o_dRdata;
    logic        o_memEn, o_memWe;
    logic [3:0]  o_memBe;
    logic [14:0] o_memAddr;
    logic [31:0] o_memWdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(15)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_ifReq(i_ifReq), .i_ifAddr(i_ifAddr), .o_ifGnt(o_ifGnt),
        .o_ifRvalid(o_ifRvalid), .o_ifRdata(o_ifRdata),
        .i_dReq(i_dReq), .i_dAddr(i_dAddr), .i_dWe(i_dWe),
        .i_dSize(i_dSize), .i_dSign(i_dSign), .i_dWdata(i_dWdata),
        .o_dGnt(o_dGnt), .o_dRvalid(o_dRvalid), .o_dRdata(o_dRdata),
        .o_dErr(o_dErr), .o_memEn(o_memEn), .o_memWe(o_memWe),
        .o_memBe(o_memBe), .o_memAddr(o_memAddr),
        .o_memWdata(o_memWdata), .i_memRdata(mem_rdata)
    );

    logic [31:0] mem [0:8191];

    always @(posedge clk) begin
        if (o_memEn) begin
            if (o_memWe) begin
                for (int b = 0; b < 4; b++)
                    if (o_memBe[b])
                        mem[o_memAddr[14:2]][8*b +: 8] <= o_memWdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[o_memAddr[14:2]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_if, input logic [31:0] data,
                        input bit err);
        sb.push_back('{is_if: is_if, data: data, err: err, due: cyc + 1});
    endtask

    // Monitor: responses are due exactly one cycle after their grant.
    exp_t e;
    always @(negedge clk) begin
        if (o_ifRvalid || o_dRvalid) begin
            if (sb.size() == 0 || sb[0].due != cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got if=%0b d=%0b expected none (cycle %0d)",
                         o_ifRvalid, o_dRvalid, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_if_valid", 32'(o_ifRvalid), 32'(e.is_if));
                chk("rsp_d_valid", 32'(o_dRvalid), 32'(!e.is_if));
                chk("rsp_data", e.is_if ? o_ifRdata : o_dRdata, e.data);
                chk("rsp_err", 32'(o_dErr), 32'(e.err));
            end
        end else if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL rsp_missing: got no rvalid expected data %h (cycle %0d)",
                     e.data, cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        i_ifReq = 1'b0;
        i_dReq  = 1'b0;
    endtask

    task automatic drive_if(input logic [31:0] a, input logic [31:0] exp,
                            input bit do_push);
        step();
        i_ifReq  = 1'b1;
        i_ifAddr = a;
        i_dReq   = 1'b0;
        #1;
        chk("if_gnt", 32'(o_ifGnt), 32'd1);
        chk("if_dgnt", 32'(o_dGnt), 32'd0);
        chk("if_en", 32'(o_memEn), 32'd1);
        chk("if_we", 32'(o_memWe), 32'd0);
        chk("if_be", 32'(o_memBe), 32'hF);
        chk("if_addr", 32'(o_memAddr), 32'(a[14:0]));
        if (do_push) push(1'b1, exp, 1'b0);
    endtask

    task automatic drive_d(input logic [31:0] a, input bit we,
                           input logic [1:0] size, input bit sgn,
                           input logic [31:0] wd, input bit exp_en,
                           input logic [3:0] exp_be,
                           input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
        step();
        i_ifReq  = 1'b0;
        i_dReq   = 1'b1;
        i_dAddr  = a;
        i_dWe    = we;
        i_dSize  = size;
        i_dSign  = sgn;
        i_dWdata = wd;
        #1;
        chk("d_gnt", 32'(o_dGnt), 32'd1);
        chk("d_ifgnt", 32'(o_ifGnt), 32'd0);
        chk("d_en", 32'(o_memEn), 32'(exp_en));
        if (exp_en) begin
            chk("d_we", 32'(o_memWe), 32'(we));
            chk("d_be", 32'(o_memBe), 32'(exp_be));
            chk("d_addr", 32'(o_memAddr), 32'(a[14:0]));
            if (we) chk("d_wdata", o_memWdata, exp_wd);
        end
        if (!we || !exp_en) push(1'b0, exp_rd, !exp_en);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ifgnt"}, 32'(o_ifGnt), 32'd0);
        chk({tag, "_dgnt"}, 32'(o_dGnt), 32'd0);
        chk({tag, "_en"}, 32'(o_memEn), 32'd0);
        chk({tag, "_we"}, 32'(o_memWe), 32'd0);
        chk({tag, "_be"}, 32'(o_memBe), 32'd0);
        chk({tag, "_addr"}, 32'(o_memAddr), 32'd0);
        chk({tag, "_wdata"}, o_memWdata, 32'd0);
        chk({tag, "_ifrv"}, 32'(o_ifRvalid), 32'd0);
        chk({tag, "_drv"}, 32'(o_dRvalid), 32'd0);
        chk({tag, "_derr"}, 32'(o_dErr), 32'd0);
        chk({tag, "_ifrd"}, o_ifRdata, 32'd0);
        chk({tag, "_drd"}, o_dRdata, 32'd0);
        chk({tag, "_starve"}, 32'(dut.starve_q), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[4]   = 32'h00500093;
        mem[128] = 32'h8899AABB;
        i_reset  = 1'b1;
        i_ifReq  = 1'b1;
        i_ifAddr = 32'h10;
        i_dReq   = 1'b1;
        i_dAddr  = 32'h200;
        i_dWe    = 1'b1;
        i_dSize  = 2'b10;
        i_dSign  = 1'b0;
        i_dWdata = 32'hDEADBEEF;

        step();
        chk_reset_outs("por");
        step();
        i_reset = 1'b0;
        i_ifReq = 1'b0;
        i_dReq  = 1'b0;

        // Fetch, then stores and a read-back of the merged word.
        drive_if(32'h10, 32'h00500093, 1'b1);
        drive_d(32'h103, 1, 2'b00, 0, 32'hAB, 1, 4'b1000, 32'hAB000000, 0);
        drive_d(32'h100, 1, 2'b01, 0, 32'h5566, 1, 4'b0011, 32'h00005566, 0);
        drive_d(32'h100, 0, 2'b10, 0, 0, 1, 4'hF, 0, 32'hAB005566);

        // Loads from 0x8899AABB.
        drive_d(32'h201, 0, 2'b00, 0, 0, 1, 4'b0010, 0, 32'hFFFFFFAA);
        drive_d(32'h201, 0, 2'b00, 1, 0, 1, 4'b0010, 0, 32'h000000AA);
        drive_d(32'h202, 0, 2'b01, 0, 0, 1, 4'b1100, 0, 32'hFFFF8899);
        drive_d(32'h200, 0, 2'b01, 1, 0, 1, 4'b0011, 0, 32'h0000AABB);
        drive_d(32'h200, 0, 2'b10, 0, 0, 1, 4'hF, 0, 32'h8899AABB);
        drive_d(32'h203, 0, 2'b00, 0, 0, 1, 4'b1000, 0, 32'hFFFFFF88);

        // Error accesses, then confirm the misaligned store wrote nothing.
        drive_d(32'h102, 0, 2'b10, 0, 0, 0, 4'h0, 0, 32'h0);
        drive_d(32'h101, 0, 2'b01, 0, 0, 0, 4'h0, 0, 32'h0);
        drive_d(32'h200, 0, 2'b11, 0, 0, 0, 4'h0, 0, 32'h0);
        drive_d(32'h101, 1, 2'b10, 0, 32'hFFFFFFFF, 0, 4'h0, 0, 32'h0);
        drive_d(32'h100, 0, 2'b10, 0, 0, 1, 4'hF, 0, 32'hAB005566);
        idle();

        // Contention: data for 4 cycles, then IF, repeating.
        for (int i = 0; i < 11; i++) begin
            bit exp_if;
            step();
            i_ifReq  = 1'b1;
            i_ifAddr = 32'h10;
            i_dReq   = 1'b1;
            i_dAddr  = 32'h200;
            i_dWe    = 1'b0;
            i_dSize  = 2'b10;
            i_dSign  = 1'b0;
            #1;
            exp_if = (i == 4) || (i == 9);
            chk("cont_ifgnt", 32'(o_ifGnt), 32'(exp_if));
            chk("cont_dgnt", 32'(o_dGnt), 32'(!exp_if));
            chk("cont_starve", 32'(dut.starve_q), 32'(i % 5));
            if (exp_if) push(1'b1, 32'h00500093, 1'b0);
            else push(1'b0, 32'h8899AABB, 1'b0);
        end
        idle();

        // Reset the cycle after a fetch grant: its response is dropped.
        drive_if(32'h10, 32'h0, 1'b0);
        step();
        i_reset = 1'b1;
        i_ifReq = 1'b1;
        i_dReq  = 1'b1;
        #1;
        chk_reset_outs("rst1a");
        step();
        chk_reset_outs("rst1b");
        step();
        i_reset = 1'b0;
        i_ifReq = 1'b0;
        i_dReq  = 1'b0;

        // Build up starvation, then reset clears it.
        for (int i = 0; i < 3; i++) begin
            step();
            i_ifReq  = 1'b1;
            i_ifAddr = 32'h10;
            i_dReq   = 1'b1;
            i_dAddr  = 32'h200;
            i_dWe    = 1'b0;
            i_dSize  = 2'b10;
            #1;
            chk("pre_starve", 32'(dut.starve_q), 32'(i));
            if (i < 2) push(1'b0, 32'h8899AABB, 1'b0);
        end
        step();
        i_reset = 1'b1;
        #1;
        chk_reset_outs("rst2");
        step();
        i_reset = 1'b0;
        i_ifReq = 1'b0;
        i_dReq  = 1'b0;

        drive_if(32'h10, 32'h00500093, 1'b1);
        idle();
        idle();
        idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
